// File: rtl/sseg_pkg.sv
// Shared 7-segment definitions for the display driver and the capture monitor.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Patterns are active low, bit order g..a in [6:0].
package sseg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sseg_decode.sv
// Maps an active-low 7-segment pattern back to its hex value.
// Latency: combinational.
// Backpressure: none.
// Ports: seg[6:0] in (g..a, active low); hex[3:0] out (0 on error); err out
// (pattern is not one of the 16 hex glyphs, blank included).
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       err
);

  always_comb begin
    hex = 4'h0;
    err = 1'b0;
    case (seg)
      SEG_0:   hex = 4'h0;
      SEG_1:   hex = 4'h1;
      SEG_2:   hex = 4'h2;
      SEG_3:   hex = 4'h3;
      SEG_4:   hex = 4'h4;
      SEG_5:   hex = 4'h5;
      SEG_6:   hex = 4'h6;
      SEG_7:   hex = 4'h7;
      SEG_8:   hex = 4'h8;
      SEG_9:   hex = 4'h9;
      SEG_A:   hex = 4'hA;
      SEG_B:   hex = 4'hB;
      SEG_C:   hex = 4'hC;
      SEG_D:   hex = 4'hD;
      SEG_E:   hex = 4'hE;
      SEG_F:   hex = 4'hF;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/sseg_scan_capture.sv
// Captures a multiplexed active-low 7-segment display back into hex digits.
// Latency: SETTLE+1 cycles from a stable pattern to registered outputs (+2 with SSEG_CAP_SYNC_EN).
// Backpressure: none; dwells shorter than SETTLE+1 cycles are silently dropped.
// Ports: clk, reset (async, active high); an[7:0] digit enables (active low);
// sseg[7:0] segments (active low, [7]=~dp); digits[31:0] hex nibble per digit;
// dp_out[7:0]; seg_err[7:0]; digit_valid[7:0] (sticky); frame_done (1-cycle pulse).
// Build option: define SSEG_CAP_SYNC_EN to put a 2-flop synchroniser on an/sseg.
module sseg_scan_capture
  import sseg_pkg::*;
#(
  parameter int SETTLE = 4,
  parameter int CNT_W  = $clog2(SETTLE + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_DIGITS-1:0]     an,
  input  logic [7:0]                sseg,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic [NUM_DIGITS-1:0]     dp_out,
  output logic [NUM_DIGITS-1:0]     seg_err,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic                      frame_done
);

  localparam int SAMP_W = NUM_DIGITS + 8;

  logic [SAMP_W-1:0]     samp;
  logic [SAMP_W-1:0]     s_q;
  logic [CNT_W-1:0]      cnt;
  logic [NUM_DIGITS-1:0] an_act;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_nxt;
  logic                  same;
  logic                  capture;
  logic [3:0]            dec_hex;
  logic                  dec_err;

`ifdef SSEG_CAP_SYNC_EN
  logic [SAMP_W-1:0] sync1;
  logic [SAMP_W-1:0] sync2;

  // Reset to all ones so the synchroniser looks like a blank, deselected display.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {an, sseg};
      sync2 <= sync1;
    end
  end

  assign samp = sync2;
`else
  assign samp = {an, sseg};
`endif

  assign same   = (samp == s_q);
  assign an_act = ~samp[SAMP_W-1:8];

  // Counter saturates at SETTLE so a long dwell captures exactly once; the
  // capture fires on the edge that would move it from SETTLE-1 to SETTLE.
  assign capture = same && (cnt == CNT_W'(SETTLE - 1)) && $onehot(an_act);

  assign seen_nxt = seen | an_act;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q <= '1;
      cnt <= '0;
    end else begin
      s_q <= samp;
      if (!same) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(SETTLE)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  sseg_decode u_decode (
    .seg (samp[6:0]),
    .hex (dec_hex),
    .err (dec_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits      <= '0;
      dp_out      <= '0;
      seg_err     <= '0;
      digit_valid <= '0;
      seen        <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (capture) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (an_act[i]) begin
            digits[4*i +: 4] <= dec_hex;
            dp_out[i]        <= ~samp[7];
            seg_err[i]       <= dec_err;
            digit_valid[i]   <= 1'b1;
          end
        end
        // The eighth distinct digit closes the frame; tracking restarts on the same edge.
        if (&seen_nxt) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen_nxt;
        end
      end
    end
  end

endmodule
